// File: rtl/store_unit_pkg.sv
// Shared store-unit definitions: store ops, FSM states and funct3 encodings.
package store_unit_pkg;

    typedef enum logic [1:0] {
        StoreOpSb = 2'b00,
        StoreOpSh = 2'b01,
        StoreOpSw = 2'b10,
        StoreOpSd = 2'b11
    } store_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBeat0 = 2'b01,
        StBeat1 = 2'b10,
        StResp  = 2'b11
    } store_state_e;

    localparam logic [2:0] F3Sb = 3'b000;
    localparam logic [2:0] F3Sh = 3'b001;
    localparam logic [2:0] F3Sw = 3'b010;
    localparam logic [2:0] F3Sd = 3'b011;

    function automatic logic [3:0] op_bytes(store_op_e op);
        return 4'd1 << op;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Request and data-memory bus signals of the store unit.
interface store_unit_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned NB = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [NB-1:0]   mem_wstrb;
    logic            done;
    logic            fault;

    modport master (
        output req_valid, req_funct3, req_addr, req_wdata, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, fault
    );

    modport slave (
        input  req_valid, req_funct3, req_addr, req_wdata, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, fault
    );
endinterface

// File: rtl/store_lane_align.sv
// Combinational funct3 decode, byte-lane strobe mask and data shift over two bus words.
module store_lane_align
    import store_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]                funct3,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [XLEN-1:0]           wdata,
    output logic                      legal,
    output logic                      misaligned,
    output logic                      split,
    output logic [2*(XLEN/8)-1:0]     s,
    output logic [2*XLEN-1:0]         d
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned SW = 2 * NB;

    logic [3:0]    nbytes;
    logic [SW-1:0] mask;

    always_comb begin
        legal  = (funct3[2] == 1'b0) && !((funct3 == F3Sd) && (XLEN != 64));
        nbytes = op_bytes(store_op_e'(funct3[1:0]));
        mask   = legal ? SW'((16'd1 << nbytes) - 16'd1) : '0;
        misaligned = legal && ((4'(off) & (nbytes - 4'd1)) != 4'd0);
        s     = mask << off;
        d     = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
        split = |s[SW-1:NB];
    end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store sequencer: registers a request, issues one or two aligned bus beats, then responds.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input logic        clk,
    input logic        resetn,
    store_unit_if.slave bus
);
    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OffW = $clog2(NB);

    store_state_e    state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] data0_q, data0_d;
    logic [XLEN-1:0] data1_q, data1_d;
    logic [NB-1:0]   strb0_q, strb0_d;
    logic [NB-1:0]   strb1_q, strb1_d;
    logic            split_q, split_d;
    logic            fault_q, fault_d;

    logic              legal;
    logic              misaligned;
    logic              split;
    logic [2*NB-1:0]   s;
    logic [2*XLEN-1:0] d;
    logic              req_fault;

    store_lane_align #(
        .XLEN(XLEN)
    ) u_align (
        .funct3    (bus.req_funct3),
        .off       (bus.req_addr[OffW-1:0]),
        .wdata     (bus.req_wdata),
        .legal     (legal),
        .misaligned(misaligned),
        .split     (split),
        .s         (s),
        .d         (d)
    );

    assign req_fault = !legal || (misaligned && !MISALIGN_EN);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data0_d = data0_q;
        data1_d = data1_q;
        strb0_d = strb0_q;
        strb1_d = strb1_q;
        split_d = split_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d  = {bus.req_addr[XLEN-1:OffW], {OffW{1'b0}}};
                    data0_d = d[XLEN-1:0];
                    data1_d = d[2*XLEN-1:XLEN];
                    strb0_d = s[NB-1:0];
                    strb1_d = s[2*NB-1:NB];
                    split_d = split;
                    fault_d = req_fault;
                    state_d = req_fault ? StResp : StBeat0;
                end
            end
            StBeat0: if (bus.mem_ready) state_d = split_q ? StBeat1 : StResp;
            StBeat1: if (bus.mem_ready) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data0_q <= '0;
            data1_q <= '0;
            strb0_q <= '0;
            strb1_q <= '0;
            split_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            strb0_q <= strb0_d;
            strb1_q <= strb1_d;
            split_q <= split_d;
            fault_q <= fault_d;
        end
    end

    // Bus payload is zero outside the beat states so idle outputs match reset.
    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.done      = 1'b0;
        bus.fault     = 1'b0;
        unique case (state_q)
            StBeat0: begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = data0_q;
                bus.mem_wstrb = strb0_q;
            end
            StBeat1: begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = addr_q + XLEN'(NB);
                bus.mem_wdata = data1_q;
                bus.mem_wstrb = strb1_q;
            end
            StResp: begin
                bus.done  = 1'b1;
                bus.fault = fault_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_unit.sv
// Randomised and directed bench for store_unit across XLEN=32/64 and both misalignment modes.
module tb_store_unit;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int sel = 0;

    logic        req_valid = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        mem_ready = 1'b1;

    logic        o_ready, o_mem_valid, o_done, o_fault;
    logic [63:0] o_addr, o_wdata;
    logic [7:0]  o_strb;

    // a: XLEN=32 split enabled, b: XLEN=32 faulting, c: XLEN=64 split enabled
    store_unit_if #(.XLEN(32)) if_a ();
    store_unit_if #(.XLEN(32)) if_b ();
    store_unit_if #(.XLEN(64)) if_c ();

    store_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) u_dut_a (.clk(clk), .resetn(resetn), .bus(if_a));
    store_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) u_dut_b (.clk(clk), .resetn(resetn), .bus(if_b));
    store_unit #(.XLEN(64), .MISALIGN_EN(1'b1)) u_dut_c (.clk(clk), .resetn(resetn), .bus(if_c));

    assign if_a.req_valid  = req_valid && (sel == 0);
    assign if_b.req_valid  = req_valid && (sel == 1);
    assign if_c.req_valid  = req_valid && (sel == 2);
    assign if_a.mem_ready  = mem_ready && (sel == 0);
    assign if_b.mem_ready  = mem_ready && (sel == 1);
    assign if_c.mem_ready  = mem_ready && (sel == 2);
    assign if_a.req_funct3 = req_funct3;
    assign if_b.req_funct3 = req_funct3;
    assign if_c.req_funct3 = req_funct3;
    assign if_a.req_addr   = req_addr[31:0];
    assign if_b.req_addr   = req_addr[31:0];
    assign if_c.req_addr   = req_addr;
    assign if_a.req_wdata  = req_wdata[31:0];
    assign if_b.req_wdata  = req_wdata[31:0];
    assign if_c.req_wdata  = req_wdata;

    always_comb begin
        o_ready     = if_a.req_ready;
        o_mem_valid = if_a.mem_valid;
        o_done      = if_a.done;
        o_fault     = if_a.fault;
        o_addr      = 64'(if_a.mem_addr);
        o_wdata     = 64'(if_a.mem_wdata);
        o_strb      = 8'(if_a.mem_wstrb);
        if (sel == 1) begin
            o_ready     = if_b.req_ready;
            o_mem_valid = if_b.mem_valid;
            o_done      = if_b.done;
            o_fault     = if_b.fault;
            o_addr      = 64'(if_b.mem_addr);
            o_wdata     = 64'(if_b.mem_wdata);
            o_strb      = 8'(if_b.mem_wstrb);
        end else if (sel == 2) begin
            o_ready     = if_c.req_ready;
            o_mem_valid = if_c.mem_valid;
            o_done      = if_c.done;
            o_fault     = if_c.fault;
            o_addr      = if_c.mem_addr;
            o_wdata     = if_c.mem_wdata;
            o_strb      = if_c.mem_wstrb;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut=%0d got=%h exp=%h t=%0t", tag, sel, got, exp, $time);
        end
    endtask

    // Byte-level model: byte k of the store lands at address addr+k.
    function automatic logic [63:0] exp_beat_data(int nb, logic [63:0] wd, int off, int b);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < nb; j++) begin
            int k = b * nb + j - off;
            if (k >= 0 && k < nb) r[8*j +: 8] = wd[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_beat_strb(int nb, int size, int off, int b);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < nb; j++) begin
            int k = b * nb + j - off;
            if (k >= 0 && k < size) r[j] = 1'b1;
        end
        return r;
    endfunction

    task automatic do_store(input int dut, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] wdata, input bit stall);
        int nb, size, off, nbeats, cyc, bi;
        bit legal, mis_en, exp_fault, seen_done;
        logic [63:0] amask, a, wd, base;
        nb        = (dut == 2) ? 8 : 4;
        mis_en    = (dut != 1);
        amask     = (nb == 8) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
        a         = addr & amask;
        wd        = wdata & amask;
        legal     = (f3[2] == 1'b0) && !(f3 == 3'b011 && nb == 4);
        size      = legal ? (1 << f3[1:0]) : 0;
        off       = int'(a % 64'(nb));
        exp_fault = !legal || (!mis_en && (off % size) != 0);
        nbeats    = exp_fault ? 0 : ((off + size > nb) ? 2 : 1);
        base      = a - 64'(off);
        sel       = dut;
        mem_ready = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", 64'(o_ready), 64'd1);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_funct3 = 3'($urandom);
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
        bi         = 0;
        seen_done  = 1'b0;
        cyc        = 1;
        while (!seen_done && cyc <= 60) begin
            mem_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            check_eq("busy_not_ready", 64'(o_ready), 64'(o_done ? 0 : 0));
            if (o_mem_valid) begin
                check_eq("beat_expected", 64'(bi < nbeats), 64'd1);
                if (bi < nbeats) begin
                    check_eq("beat_addr", o_addr, (base + 64'(bi * nb)) & amask);
                    check_eq("beat_strb", 64'(o_strb), 64'(exp_beat_strb(nb, size, off, bi)));
                    check_eq("beat_data", o_wdata, exp_beat_data(nb, wd, off, bi));
                end
                if (mem_ready) bi++;
            end
            if (o_done) begin
                seen_done = 1'b1;
                check_eq("fault", 64'(o_fault), 64'(exp_fault));
                check_eq("beat_count", 64'(bi), 64'(nbeats));
                if (!stall) check_eq("latency", 64'(cyc), 64'(nbeats + 1));
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("done_seen", 64'(seen_done), 64'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        check_eq("done_one_cycle", 64'(o_done), 64'd0);
        check_eq("back_to_idle", 64'(o_ready), 64'd1);
    endtask

    task automatic reset_mid_op();
        sel       = 0;
        mem_ready = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 64'h4000;
        req_wdata  = 64'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", 64'(o_mem_valid), 64'd1);
            check_eq("stall_addr", o_addr, 64'h4000);
            check_eq("stall_strb", 64'(o_strb), 64'hf);
            check_eq("stall_data", o_wdata, 64'hCAFE_F00D);
            check_eq("stall_no_done", 64'(o_done), 64'd0);
            @(negedge clk);
        end
        #2 resetn = 1'b0;
        #1;
        check_eq("rst_valid_drop", 64'(o_mem_valid), 64'd0);
        check_eq("rst_addr", o_addr, 64'd0);
        check_eq("rst_ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        resetn    = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_done", 64'(o_done), 64'd0);
            check_eq("post_rst_ready", 64'(o_ready), 64'd1);
            check_eq("post_rst_no_valid", 64'(o_mem_valid), 64'd0);
        end
    endtask

    initial begin
        #3;
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            check_eq("reset_ready", 64'(o_ready), 64'd1);
            check_eq("reset_valid", 64'(o_mem_valid), 64'd0);
            check_eq("reset_done", 64'(o_done), 64'd0);
            check_eq("reset_fault", 64'(o_fault), 64'd0);
            check_eq("reset_addr", o_addr, 64'd0);
            check_eq("reset_strb", 64'(o_strb), 64'd0);
            check_eq("reset_data", o_wdata, 64'd0);
        end
        @(negedge clk);
        resetn = 1'b1;

        do_store(0, 3'b010, 64'h1000, 64'hDEAD_BEEF, 1'b0);
        do_store(0, 3'b000, 64'h2003, 64'h0000_00A5, 1'b0);
        do_store(0, 3'b010, 64'h3002, 64'h1122_3344, 1'b0);
        do_store(1, 3'b010, 64'h3002, 64'h1122_3344, 1'b0);
        do_store(0, 3'b001, 64'h3001, 64'h0000_BEEF, 1'b0);
        do_store(1, 3'b001, 64'h3002, 64'h0000_BEEF, 1'b0);
        do_store(0, 3'b011, 64'h5000, 64'h1234_5678, 1'b0);
        do_store(0, 3'b100, 64'h5000, 64'h1234_5678, 1'b0);
        do_store(2, 3'b011, 64'h8, 64'h0123_4567_89AB_CDEF, 1'b0);
        do_store(2, 3'b010, 64'hE, 64'hA1B2_C3D4, 1'b0);
        do_store(2, 3'b111, 64'h10, 64'h1, 1'b0);
        reset_mid_op();

        for (int i = 0; i < 150; i++) begin
            logic [2:0] f3;
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            do_store($urandom_range(0, 2), f3, {$urandom, $urandom}, {$urandom, $urandom},
                     ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule
